alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_pkg.sv | 50 +++++
 rtl/alu_op_decode.sv | 51 +++++
 rtl/alu_ctrl_seq.sv | 99 +++++++++
 tb/tb_alu_ctrl_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: main-control op classes,
// R-type function fields, ALU select codes and the sequencer state type.
package alu_ctrl_pkg;

    // Wide enough for the largest execution latency (DIV_LAT up to 63)
    localparam int CNT_W = 6;

    // ALUOp classes from main control
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_SLT   = 3'b100;
    localparam logic [2:0] OP_RTYPE = 3'b101;
    localparam logic [2:0] OP_XORI  = 3'b110;
    localparam logic [2:0] OP_LUI   = 3'b111;

    // R-type Func field values
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_NOP = 6'b000000;
    localparam logic [5:0] FN_MUL = 6'b000010;
    localparam logic [5:0] FN_DIV = 6'b011010;

    // ALU select codes
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_MUL = 4'b0011;
    localparam logic [3:0] SEL_DIV = 4'b0100;
    localparam logic [3:0] SEL_XOR = 4'b0101;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOP = 4'b1000;
    localparam logic [3:0] SEL_LUI = 4'b1001;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        DONE
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational ALUOp/Func decode into a 4-bit ALU select code plus
// flags marking the multi-cycle operations.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] ALUOp,
    input  logic [5:0] Func,
    output logic [3:0] code,
    output logic       is_mul,
    output logic       is_div
);

    // Map op class (and Func for R-type) to select code; unknown Func falls back to ADD
    always_comb begin
        code   = SEL_ADD;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (ALUOp)
            OP_ADD:  code = SEL_ADD;
            OP_SUB:  code = SEL_SUB;
            OP_AND:  code = SEL_AND;
            OP_OR:   code = SEL_OR;
            OP_SLT:  code = SEL_SLT;
            OP_XORI: code = SEL_XOR;
            OP_LUI:  code = SEL_LUI;
            OP_RTYPE: begin
                case (Func)
                    FN_ADD: code = SEL_ADD;
                    FN_AND: code = SEL_AND;
                    FN_SLT: code = SEL_SLT;
                    FN_SUB: code = SEL_SUB;
                    FN_OR:  code = SEL_OR;
                    FN_XOR: code = SEL_XOR;
                    FN_NOR: code = SEL_NOR;
                    FN_NOP: code = SEL_NOP;
                    FN_MUL: begin
                        code   = SEL_MUL;
                        is_mul = 1'b1;
                    end
                    FN_DIV: begin
                        code   = SEL_DIV;
                        is_div = 1'b1;
                    end
                    default: code = SEL_ADD;
                endcase
            end
            default: code = SEL_ADD;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registers the decoded select code and stalls the
// upstream stage for the fixed latency of MUL/DIV, then pulses done.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       Func,
    input  logic             b_zero,
    output logic [SEL_W-1:0] sel,
    output logic             stall,
    output logic             done,
    output logic             div0
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;

    logic [3:0]         dec_code;
    logic               dec_mul;
    logic               dec_div;

    alu_op_decode u_decode (
        .ALUOp  (ALUOp),
        .Func   (Func),
        .code   (dec_code),
        .is_mul (dec_mul),
        .is_div (dec_div)
    );

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_W'(SEL_ADD);
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    // Next-state logic; DONE accepts a new op exactly like IDLE so ops can run back-to-back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (valid_in) begin
                    sel_d = SEL_W'(dec_code);
                    if (dec_mul) begin
                        state_d = MUL_RUN;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end else if (dec_div && !b_zero) begin
                        state_d = DIV_RUN;
                        cnt_d   = CNT_W'(DIV_LAT - 1);
                    end else begin
                        // Single-cycle ops and divide-by-zero finish immediately
                        done_d = 1'b1;
                        div0_d = dec_div & b_zero;
                    end
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel   = sel_q;
    assign stall = (state_q == MUL_RUN) || (state_q == DIV_RUN);
    assign done  = done_q;
    assign div0  = div0_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, directed multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_alu_ctrl_seq;

    localparam int SEL_W   = 4;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_in;
    logic [2:0]       ALUOp;
    logic [5:0]       Func;
    logic             b_zero;
    logic [SEL_W-1:0] sel;
    logic             stall;
    logic             done;
    logic             div0;

    int n_cmp = 0;
    int n_err = 0;

    alu_ctrl_seq #(
        .SEL_W   (SEL_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .ALUOp    (ALUOp),
        .Func     (Func),
        .b_zero   (b_zero),
        .sel      (sel),
        .stall    (stall),
        .done     (done),
        .div0     (div0)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted op pushes its whole future output trace
    typedef struct packed {
        logic [3:0] sel;
        logic       stall;
        logic       done;
        logic       div0;
    } out_t;

    out_t cur;
    out_t trace_q[$];

    function automatic logic [3:0] ref_code(input logic [2:0] op, input logic [5:0] fn);
        logic [3:0] c;
        case (op)
            3'b000: c = 4'b0010;
            3'b001: c = 4'b0110;
            3'b010: c = 4'b0000;
            3'b011: c = 4'b0001;
            3'b100: c = 4'b0111;
            3'b110: c = 4'b0101;
            3'b111: c = 4'b1001;
            default: begin
                case (fn)
                    6'd32:   c = 4'b0010;
                    6'd36:   c = 4'b0000;
                    6'd42:   c = 4'b0111;
                    6'd34:   c = 4'b0110;
                    6'd37:   c = 4'b0001;
                    6'd38:   c = 4'b0101;
                    6'd39:   c = 4'b1100;
                    6'd0:    c = 4'b1000;
                    6'd2:    c = 4'b0011;
                    6'd26:   c = 4'b0100;
                    default: c = 4'b0010;
                endcase
            end
        endcase
        return c;
    endfunction

    function automatic void model_edge();
        logic [3:0] c;
        bit is_mul, is_div;
        if (!rst_n) begin
            trace_q.delete();
            cur = '{sel: 4'b0010, stall: 1'b0, done: 1'b0, div0: 1'b0};
            return;
        end
        if (valid_in && !cur.stall) begin
            c      = ref_code(ALUOp, Func);
            is_mul = (ALUOp == 3'b101) && (Func == 6'd2);
            is_div = (ALUOp == 3'b101) && (Func == 6'd26);
            trace_q.delete();
            if (is_mul || (is_div && !b_zero)) begin
                for (int k = 0; k < (is_mul ? MUL_LAT : DIV_LAT); k++)
                    trace_q.push_back('{sel: c, stall: 1'b1, done: 1'b0, div0: 1'b0});
                trace_q.push_back('{sel: c, stall: 1'b0, done: 1'b1, div0: 1'b0});
            end else begin
                trace_q.push_back('{sel: c, stall: 1'b0, done: 1'b1, div0: is_div});
            end
        end
        if (trace_q.size() > 0)
            cur = trace_q.pop_front();
        else
            cur = '{sel: cur.sel, stall: 1'b0, done: 1'b0, div0: 1'b0};
    endfunction

    // Every clock edge goes through here so the model stays in lockstep
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {sel,stall,done,div0}=0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] s, input logic st,
                              input logic dn, input logic d0);
        check(name, {sel, stall, done, div0}, {s, st, dn, d0});
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic bz);
        valid_in = v;
        ALUOp    = op;
        Func     = fn;
        b_zero   = bz;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 6'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] code;
    } vec_t;

    vec_t vt[16];
    logic [5:0] fn_pool[11];

    initial begin
        vt[0]  = '{op: 3'b000, fn: 6'b000010, code: 4'b0010};
        vt[1]  = '{op: 3'b001, fn: 6'b011010, code: 4'b0110};
        vt[2]  = '{op: 3'b010, fn: 6'b000000, code: 4'b0000};
        vt[3]  = '{op: 3'b011, fn: 6'b100000, code: 4'b0001};
        vt[4]  = '{op: 3'b100, fn: 6'b111111, code: 4'b0111};
        vt[5]  = '{op: 3'b110, fn: 6'b000010, code: 4'b0101};
        vt[6]  = '{op: 3'b111, fn: 6'b100111, code: 4'b1001};
        vt[7]  = '{op: 3'b101, fn: 6'b100000, code: 4'b0010};
        vt[8]  = '{op: 3'b101, fn: 6'b100100, code: 4'b0000};
        vt[9]  = '{op: 3'b101, fn: 6'b101010, code: 4'b0111};
        vt[10] = '{op: 3'b101, fn: 6'b100010, code: 4'b0110};
        vt[11] = '{op: 3'b101, fn: 6'b100101, code: 4'b0001};
        vt[12] = '{op: 3'b101, fn: 6'b100110, code: 4'b0101};
        vt[13] = '{op: 3'b101, fn: 6'b100111, code: 4'b1100};
        vt[14] = '{op: 3'b101, fn: 6'b000000, code: 4'b1000};
        vt[15] = '{op: 3'b101, fn: 6'b111111, code: 4'b0010};
        fn_pool = '{6'b100000, 6'b100100, 6'b101010, 6'b100010, 6'b100101, 6'b100110,
                    6'b100111, 6'b000000, 6'b000010, 6'b011010, 6'b011010};

        rst_n = 1'b0;
        drive(1'b0, 3'b000, 6'd0, 1'b0);
        do_reset();
        expect_out("reset", 4'b0010, 1'b0, 1'b0, 1'b0);

        // Basic R-type ADD, latency 1
        drive(1'b1, 3'b101, 6'b100000, 1'b0);
        tick();
        expect_out("rtype_add", 4'b0010, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 6'd0, 1'b0);
        tick();
        expect_out("rtype_add_idle", 4'b0010, 1'b0, 1'b0, 1'b0);

        // Decode table: done pulse, then sel held with done low
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vt[i].op, vt[i].fn, i[0]);
            tick();
            expect_out($sformatf("table%0d", i), vt[i].code, 1'b0, 1'b1, 1'b0);
            drive(1'b0, vt[i].op, vt[i].fn, 1'b0);
            tick();
            expect_out($sformatf("table%0d_hold", i), vt[i].code, 1'b0, 1'b0, 1'b0);
        end

        // MUL: exactly MUL_LAT stall cycles then one done
        drive(1'b1, 3'b101, 6'b000010, 1'b0);
        for (int i = 0; i < MUL_LAT; i++) begin
            tick();
            drive(1'b0, 3'b000, 6'd0, 1'b0);
            expect_out($sformatf("mul_stall%0d", i), 4'b0011, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_out("mul_done", 4'b0011, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("mul_after", 4'b0011, 1'b0, 1'b0, 1'b0);

        // DIV by zero: immediate done with div0
        drive(1'b1, 3'b101, 6'b011010, 1'b1);
        tick();
        expect_out("div0_done", 4'b0100, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 3'b000, 6'd0, 1'b0);
        tick();
        expect_out("div0_after", 4'b0100, 1'b0, 1'b0, 1'b0);

        // DIV with valid/AND toggling during stall, all ignored
        drive(1'b1, 3'b101, 6'b011010, 1'b0);
        for (int i = 0; i < DIV_LAT; i++) begin
            tick();
            drive(i[0] == 1'b0, 3'b101, 6'b100100, i[1]);
            expect_out($sformatf("div_stall%0d", i), 4'b0100, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b0, 3'b000, 6'd0, 1'b0);
        tick();
        expect_out("div_done", 4'b0100, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("div_after", 4'b0100, 1'b0, 1'b0, 1'b0);

        // Reset on second MUL stall cycle aborts with no done
        drive(1'b1, 3'b101, 6'b000010, 1'b0);
        tick();
        drive(1'b0, 3'b000, 6'd0, 1'b0);
        tick();
        expect_out("abort_stall2", 4'b0011, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        expect_out("abort_reset", 4'b0010, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            tick();
            expect_out($sformatf("abort_quiet%0d", i), 4'b0010, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 3'b011, 6'd0, 1'b0);
        tick();
        expect_out("abort_first_op", 4'b0001, 1'b0, 1'b1, 1'b0);

        // Back-to-back: XORI accepted in MUL done cycle
        drive(1'b1, 3'b101, 6'b000010, 1'b0);
        for (int i = 0; i < MUL_LAT; i++) begin
            tick();
            drive(1'b0, 3'b000, 6'd0, 1'b0);
        end
        tick();
        expect_out("b2b_mul_done", 4'b0011, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b110, 6'd0, 1'b0);
        tick();
        expect_out("b2b_xori", 4'b0101, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 6'd0, 1'b0);
        tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(99) != 0);
            valid_in = ($urandom_range(2) != 0);
            ALUOp    = ($urandom_range(1) != 0) ? 3'b101 : 3'($urandom);
            Func     = ($urandom_range(4) != 0) ? fn_pool[$urandom_range(10)] : 6'($urandom);
            b_zero   = ($urandom_range(2) == 0);
            tick();
            expect_out($sformatf("rand%0d", i), cur.sel, cur.stall, cur.done, cur.div0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
